// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter with lock that shares one accumulator ALU between two
// requesters. Idle cycles drive an OR-with-zero NOP so the accumulator holds.
module alu_share_arbiter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_L,

    input  logic             req0_valid,
    input  logic             req0_lock,
    input  logic [1:0]       req0_operation,
    input  logic [3:0]       req0_operand,
    output logic             req0_ready,
    output logic             rsp0_valid,
    output logic [3:0]       rsp0_data,

    input  logic             req1_valid,
    input  logic             req1_lock,
    input  logic [1:0]       req1_operation,
    input  logic [3:0]       req1_operand,
    output logic             req1_ready,
    output logic             rsp1_valid,
    output logic [3:0]       rsp1_data,

    output logic [1:0]       alu_operation,
    output logic [3:0]       alu_operand,
    input  logic [3:0]       alu_result,

    output logic [1:0]       owner,
    output logic [CNT_W-1:0] op_count
);

    localparam int unsigned OP_W   = 2;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned OWN_W  = 2;

    localparam logic [OP_W-1:0]   OP_NOP      = OP_W'(2);
    localparam logic [DATA_W-1:0] OPERAND_NOP = '0;
    localparam logic [CNT_W-1:0]  CNT_MAX     = '1;

    localparam logic [OWN_W-1:0]  OWNER_NONE  = OWN_W'(0);
    localparam logic [OWN_W-1:0]  OWNER_REQ0  = OWN_W'(1);
    localparam logic [OWN_W-1:0]  OWNER_REQ1  = OWN_W'(2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               rr_ptr_q, rr_ptr_d;
    logic               rsp0_valid_q, rsp0_valid_d;
    logic               rsp1_valid_q, rsp1_valid_d;
    logic [OWN_W-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]   op_count_q, op_count_d;

    logic               grant0;
    logic               grant1;
    logic               accept;

    // Arbitration and ownership FSM: grants are combinational within the cycle.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant0   = 1'b0;
        grant1   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0_valid && req1_valid) begin
                    grant0 = ~rr_ptr_q;
                    grant1 = rr_ptr_q;
                end else begin
                    grant0 = req0_valid;
                    grant1 = req1_valid;
                end

                if (grant0) begin
                    if (req0_lock) begin
                        state_d = OWN0;
                    end else begin
                        rr_ptr_d = 1'b1;
                    end
                end else if (grant1) begin
                    if (req1_lock) begin
                        state_d = OWN1;
                    end else begin
                        rr_ptr_d = 1'b0;
                    end
                end
            end

            OWN0: begin
                grant0 = req0_valid;
                // Releasing the lock ends ownership whether or not an op issues.
                if (!req0_lock) begin
                    state_d  = IDLE;
                    rr_ptr_d = 1'b1;
                end
            end

            OWN1: begin
                grant1 = req1_valid;
                if (!req1_lock) begin
                    state_d  = IDLE;
                    rr_ptr_d = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // No grant can leak to the ALU while reset is held.
        if (!reset_L) begin
            grant0 = 1'b0;
            grant1 = 1'b0;
        end
    end

    assign accept     = grant0 | grant1;
    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // ALU drive mux: the granted requester's fields, otherwise the NOP.
    always_comb begin
        alu_operation = OP_NOP;
        alu_operand   = OPERAND_NOP;
        if (grant0) begin
            alu_operation = req0_operation;
            alu_operand   = req0_operand;
        end else if (grant1) begin
            alu_operation = req1_operation;
            alu_operand   = req1_operand;
        end
    end

    // Response strobes, owner encoding and saturating accept counter.
    always_comb begin
        rsp0_valid_d = grant0;
        rsp1_valid_d = grant1;

        owner_d = OWNER_NONE;
        case (state_d)
            OWN0:    owner_d = OWNER_REQ0;
            OWN1:    owner_d = OWNER_REQ1;
            default: owner_d = OWNER_NONE;
        endcase

        op_count_d = op_count_q;
        if (accept && (op_count_q != CNT_MAX)) begin
            op_count_d = op_count_q + CNT_W'(1);
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_q      <= IDLE;
            rr_ptr_q     <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            owner_q      <= OWNER_NONE;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            owner_q      <= owner_d;
            op_count_q   <= op_count_d;
        end
    end

    // The ALU commits at the accept edge, so its result is current during the pulse.
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_data  = rsp0_valid_q ? alu_result : DATA_W'(0);
    assign rsp1_data  = rsp1_valid_q ? alu_result : DATA_W'(0);
    assign owner      = owner_q;
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural accumulator ALU.
module tb_alu_share_arbiter;

    localparam int unsigned CNT_W = 8;

    logic             clock;
    logic             reset_L;
    logic             req0_valid, req0_lock, req0_ready, rsp0_valid;
    logic [1:0]       req0_operation;
    logic [3:0]       req0_operand, rsp0_data;
    logic             req1_valid, req1_lock, req1_ready, rsp1_valid;
    logic [1:0]       req1_operation;
    logic [3:0]       req1_operand, rsp1_data;
    logic [1:0]       alu_operation;
    logic [3:0]       alu_operand;
    logic [3:0]       alu_result;
    logic [1:0]       owner;
    logic [CNT_W-1:0] op_count;

    int n_cmp;
    int n_err;

    alu_share_arbiter #(.CNT_W(CNT_W)) dut (
        .clock          (clock),
        .reset_L        (reset_L),
        .req0_valid     (req0_valid),
        .req0_lock      (req0_lock),
        .req0_operation (req0_operation),
        .req0_operand   (req0_operand),
        .req0_ready     (req0_ready),
        .rsp0_valid     (rsp0_valid),
        .rsp0_data      (rsp0_data),
        .req1_valid     (req1_valid),
        .req1_lock      (req1_lock),
        .req1_operation (req1_operation),
        .req1_operand   (req1_operand),
        .req1_ready     (req1_ready),
        .rsp1_valid     (rsp1_valid),
        .rsp1_data      (rsp1_data),
        .alu_operation  (alu_operation),
        .alu_operand    (alu_operand),
        .alu_result     (alu_result),
        .owner          (owner),
        .op_count       (op_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // External accumulator ALU: updates every clock, no enable.
    logic [3:0] acc;
    always @(posedge clock or negedge reset_L) begin
        if (!reset_L) acc <= 4'h0;
        else begin
            case (alu_operation)
                2'd0: acc <= acc + alu_operand;
                2'd1: acc <= acc - alu_operand;
                2'd2: acc <= acc | alu_operand;
                default: acc <= acc ^ alu_operand;
            endcase
        end
    end
    assign alu_result = acc;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset_L = 1'b0;
        tick();
        reset_L = 1'b1;
    endtask

    task automatic test_reset();
        reset_L = 1'b0;
        req0_valid = 1'b1; req0_lock = 1'b0; req0_operation = 2'd0; req0_operand = 4'h5;
        req1_valid = 1'b0; req1_lock = 1'b0; req1_operation = 2'd0; req1_operand = 4'h0;
        #12;
        n_cmp++; if (owner !== 2'b00) begin n_err++; $display("FAIL reset_owner got=%b exp=00", owner); end
        n_cmp++; if (rsp0_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp0_valid got=%b exp=0", rsp0_valid); end
        n_cmp++; if (rsp1_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp1_valid got=%b exp=0", rsp1_valid); end
        n_cmp++; if (op_count !== 8'd0) begin n_err++; $display("FAIL reset_op_count got=%0d exp=0", op_count); end
        n_cmp++; if (req0_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready0 got=%b exp=0", req0_ready); end
        n_cmp++; if (alu_operation !== 2'd2) begin n_err++; $display("FAIL reset_alu_op got=%0d exp=2", alu_operation); end
        n_cmp++; if (alu_operand !== 4'h0) begin n_err++; $display("FAIL reset_alu_operand got=%h exp=0", alu_operand); end
        req0_valid = 1'b0;
        tick();
        reset_L = 1'b1;
        tick();
    endtask

    task automatic test_single();
        req0_valid = 1'b1; req0_lock = 1'b0; req0_operation = 2'd0; req0_operand = 4'h5;
        #1;
        n_cmp++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL single_ready0 got=%b exp=1", req0_ready); end
        n_cmp++; if (req1_ready !== 1'b0) begin n_err++; $display("FAIL single_ready1 got=%b exp=0", req1_ready); end
        n_cmp++; if (alu_operand !== 4'h5) begin n_err++; $display("FAIL single_alu_operand got=%h exp=5", alu_operand); end
        tick();
        req0_valid = 1'b0;
        n_cmp++; if (rsp0_valid !== 1'b1) begin n_err++; $display("FAIL single_rsp0_valid got=%b exp=1", rsp0_valid); end
        n_cmp++; if (rsp0_data !== 4'h5) begin n_err++; $display("FAIL single_rsp0_data got=%h exp=5", rsp0_data); end
        n_cmp++; if (rsp1_valid !== 1'b0) begin n_err++; $display("FAIL single_rsp1_valid got=%b exp=0", rsp1_valid); end
        n_cmp++; if (op_count !== 8'd1) begin n_err++; $display("FAIL single_op_count got=%0d exp=1", op_count); end
        #1;
        n_cmp++; if (alu_operation !== 2'd2) begin n_err++; $display("FAIL idle_alu_op got=%0d exp=2", alu_operation); end
        n_cmp++; if (alu_operand !== 4'h0) begin n_err++; $display("FAIL idle_alu_operand got=%h exp=0", alu_operand); end
        tick();
        n_cmp++; if (rsp0_valid !== 1'b0) begin n_err++; $display("FAIL single_pulse_end got=%b exp=0", rsp0_valid); end
        n_cmp++; if (rsp0_data !== 4'h0) begin n_err++; $display("FAIL single_rsp0_data_idle got=%h exp=0", rsp0_data); end
        tick();
        n_cmp++; if (alu_result !== 4'h5) begin n_err++; $display("FAIL idle_acc_hold got=%h exp=5", alu_result); end
    endtask

    task automatic test_round_robin();
        logic exp0;
        logic [3:0] exp_data;
        apply_reset();
        req0_valid = 1'b1; req0_lock = 1'b0; req0_operation = 2'd0; req0_operand = 4'h1;
        req1_valid = 1'b1; req1_lock = 1'b0; req1_operation = 2'd0; req1_operand = 4'h1;
        for (int i = 0; i < 4; i++) begin
            exp0 = ((i % 2) == 0);
            exp_data = 4'(i + 1);
            #1;
            n_cmp++; if (req0_ready !== exp0 || req1_ready !== ~exp0) begin n_err++; $display("FAIL rr_grant[%0d] got=%b%b exp=%b%b", i, req1_ready, req0_ready, ~exp0, exp0); end
            tick();
            n_cmp++; if (rsp0_valid !== exp0 || rsp1_valid !== ~exp0) begin n_err++; $display("FAIL rr_rsp_valid[%0d] got=%b%b exp=%b%b", i, rsp1_valid, rsp0_valid, ~exp0, exp0); end
            n_cmp++; if ((exp0 ? rsp0_data : rsp1_data) !== exp_data) begin n_err++; $display("FAIL rr_rsp_data[%0d] got=%h exp=%h", i, exp0 ? rsp0_data : rsp1_data, exp_data); end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        n_cmp++; if (op_count !== 8'd4) begin n_err++; $display("FAIL rr_op_count got=%0d exp=4", op_count); end
    endtask

    task automatic test_lock();
        req1_valid = 1'b1; req1_lock = 1'b1; req1_operation = 2'd0; req1_operand = 4'h3;
        #1;
        n_cmp++; if (req1_ready !== 1'b1) begin n_err++; $display("FAIL lock_first_ready1 got=%b exp=1", req1_ready); end
        tick();
        n_cmp++; if (rsp1_data !== 4'h7) begin n_err++; $display("FAIL lock_add_data got=%h exp=7", rsp1_data); end
        n_cmp++; if (owner !== 2'b10) begin n_err++; $display("FAIL lock_owner1 got=%b exp=10", owner); end
        req0_valid = 1'b1; req0_lock = 1'b0; req0_operation = 2'd0; req0_operand = 4'h1;
        req1_operation = 2'd1; req1_operand = 4'h1;
        #1;
        n_cmp++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin n_err++; $display("FAIL lock_hold_sub got=%b%b exp=10", req1_ready, req0_ready); end
        tick();
        n_cmp++; if (rsp1_data !== 4'h6 || rsp0_valid !== 1'b0) begin n_err++; $display("FAIL lock_sub_rsp got=%h/%b exp=6/0", rsp1_data, rsp0_valid); end
        n_cmp++; if (owner !== 2'b10) begin n_err++; $display("FAIL lock_owner_held got=%b exp=10", owner); end
        req1_operation = 2'd3; req1_operand = 4'hF; req1_lock = 1'b0;
        #1;
        n_cmp++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin n_err++; $display("FAIL lock_release_grant got=%b%b exp=10", req1_ready, req0_ready); end
        n_cmp++; if (alu_operation !== 2'd3 || alu_operand !== 4'hF) begin n_err++; $display("FAIL lock_xor_drive got=%0d/%h exp=3/f", alu_operation, alu_operand); end
        tick();
        req1_valid = 1'b0;
        n_cmp++; if (rsp1_data !== 4'h9) begin n_err++; $display("FAIL lock_xor_data got=%h exp=9", rsp1_data); end
        n_cmp++; if (owner !== 2'b00) begin n_err++; $display("FAIL lock_owner_release got=%b exp=00", owner); end
        #1;
        n_cmp++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL lock_req0_next got=%b exp=1", req0_ready); end
        tick();
        req0_valid = 1'b0;
        n_cmp++; if (rsp0_valid !== 1'b1 || rsp0_data !== 4'hA) begin n_err++; $display("FAIL lock_req0_rsp got=%b/%h exp=1/a", rsp0_valid, rsp0_data); end
        n_cmp++; if (op_count !== 8'd8) begin n_err++; $display("FAIL lock_op_count got=%0d exp=8", op_count); end
    endtask

    task automatic test_wrap();
        logic [1:0] ops  [4] = '{2'd3, 2'd0, 2'd1, 2'd1};
        logic [3:0] opds [4] = '{4'h4, 4'h4, 4'h1, 4'h3};
        logic [3:0] exps [4] = '{4'hE, 4'h2, 4'h1, 4'hE};
        req0_valid = 1'b1; req0_lock = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req0_operation = ops[i];
            req0_operand   = opds[i];
            #1;
            n_cmp++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL wrap_ready[%0d] got=%b exp=1", i, req0_ready); end
            tick();
            n_cmp++; if (rsp0_valid !== 1'b1 || rsp0_data !== exps[i]) begin n_err++; $display("FAIL wrap_rsp[%0d] got=%b/%h exp=1/%h", i, rsp0_valid, rsp0_data, exps[i]); end
        end
        req0_valid = 1'b0;
        n_cmp++; if (op_count !== 8'd12) begin n_err++; $display("FAIL wrap_op_count got=%0d exp=12", op_count); end
    endtask

    task automatic test_reset_mid_lock();
        req0_valid = 1'b1; req0_lock = 1'b1; req0_operation = 2'd2; req0_operand = 4'h0;
        tick();
        n_cmp++; if (owner !== 2'b01) begin n_err++; $display("FAIL midrst_owner0 got=%b exp=01", owner); end
        #2;
        reset_L = 1'b0;
        #1;
        n_cmp++; if (owner !== 2'b00) begin n_err++; $display("FAIL midrst_owner got=%b exp=00", owner); end
        n_cmp++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin n_err++; $display("FAIL midrst_rsp got=%b%b exp=00", rsp1_valid, rsp0_valid); end
        n_cmp++; if (op_count !== 8'd0) begin n_err++; $display("FAIL midrst_op_count got=%0d exp=0", op_count); end
        n_cmp++; if (req0_ready !== 1'b0 || alu_operation !== 2'd2) begin n_err++; $display("FAIL midrst_nop got=%b/%0d exp=0/2", req0_ready, alu_operation); end
        req0_valid = 1'b0; req0_lock = 1'b0;
        tick();
        reset_L = 1'b1;
        req0_valid = 1'b1; req0_operation = 2'd0; req0_operand = 4'h3;
        req1_valid = 1'b1; req1_lock = 1'b0; req1_operation = 2'd0; req1_operand = 4'h7;
        #1;
        n_cmp++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_err++; $display("FAIL midrst_rr_ptr got=%b%b exp=01", req1_ready, req0_ready); end
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        n_cmp++; if (rsp0_data !== 4'h3 || op_count !== 8'd1) begin n_err++; $display("FAIL midrst_first_rsp got=%h/%0d exp=3/1", rsp0_data, op_count); end
    endtask

    task automatic test_saturation();
        logic [CNT_W-1:0] exp_cnt;
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_lock = 1'b0; req0_operation = 2'd0; req0_operand = 4'h1;
        for (int i = 0; i < 260; i++) begin
            tick();
            exp_cnt = (i + 2 > 255) ? 8'd255 : 8'(i + 2);
            if (i == 252 || i == 253 || i == 259) begin
                n_cmp++; if (op_count !== exp_cnt) begin n_err++; $display("FAIL sat_count[%0d] got=%0d exp=%0d", i, op_count, exp_cnt); end
            end
        end
        req0_valid = 1'b0;
        tick();
        n_cmp++; if (op_count !== 8'd255) begin n_err++; $display("FAIL sat_hold got=%0d exp=255", op_count); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_wrap();
        test_reset_mid_lock();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
